// File: rtl/wb_arbiter_if.sv
// Bundle of the two master ports and the shared slave port of wb_arbiter.
// The master modport is the arbiter's view; the slave modport is the environment's view.
interface wb_arbiter_if #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 16
);
    logic          m0_cyc_i;
    logic          m0_stb_i;
    logic [AW-1:0] m0_addr_i;
    logic          m0_stall_o;
    logic          m0_ack_o;
    logic [DW-1:0] m0_data_o;

    logic          m1_cyc_i;
    logic          m1_stb_i;
    logic          m1_we_i;
    logic [AW-1:0] m1_addr_i;
    logic [DW-1:0] m1_data_i;
    logic          m1_stall_o;
    logic          m1_ack_o;
    logic [DW-1:0] m1_data_o;

    logic          s_cyc_o;
    logic          s_stb_o;
    logic          s_we_o;
    logic [AW-1:0] s_addr_o;
    logic [DW-1:0] s_data_o;
    logic          s_stall_i;
    logic          s_ack_i;
    logic [DW-1:0] s_data_i;

    modport master (
        input  m0_cyc_i, m0_stb_i, m0_addr_i,
        output m0_stall_o, m0_ack_o, m0_data_o,
        input  m1_cyc_i, m1_stb_i, m1_we_i, m1_addr_i, m1_data_i,
        output m1_stall_o, m1_ack_o, m1_data_o,
        output s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o,
        input  s_stall_i, s_ack_i, s_data_i
    );

    modport slave (
        output m0_cyc_i, m0_stb_i, m0_addr_i,
        input  m0_stall_o, m0_ack_o, m0_data_o,
        output m1_cyc_i, m1_stb_i, m1_we_i, m1_addr_i, m1_data_i,
        input  m1_stall_o, m1_ack_o, m1_data_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o,
        output s_stall_i, s_ack_i, s_data_i
    );
endinterface

// File: rtl/wb_arbiter.sv
// Two-master pipelined WISHBONE arbiter: FETCH (m0, read-only) and data path (m1)
// share one slave. Whole-cycle grants, round-robin on ties, no preemption.
module wb_arbiter #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    wb_arbiter_if.master bus
);
    typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

    state_e     state_q, state_d;
    logic       last_gnt_q, last_gnt_d;
    logic [3:0] cnt_q, cnt_d;

    logic          s_cyc, s_stb, s_we;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic          m0_stall, m1_stall, m0_ack, m1_ack;
    logic          inc, dec;

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        s_cyc      = 1'b0;
        s_stb      = 1'b0;
        s_we       = 1'b0;
        s_addr     = '0;
        s_wdata    = '0;
        m0_stall   = 1'b1;
        m1_stall   = 1'b1;
        m0_ack     = 1'b0;
        m1_ack     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.m0_cyc_i && bus.m1_cyc_i) begin
                    state_d = last_gnt_q ? StGnt0 : StGnt1;
                end else if (bus.m0_cyc_i) begin
                    state_d = StGnt0;
                end else if (bus.m1_cyc_i) begin
                    state_d = StGnt1;
                end
            end
            StGnt0: begin
                s_cyc    = bus.m0_cyc_i;
                s_stb    = bus.m0_cyc_i & bus.m0_stb_i;
                s_addr   = bus.m0_addr_i;
                m0_stall = bus.s_stall_i;
                m0_ack   = bus.s_ack_i & bus.m0_cyc_i & (cnt_q != 4'd0);
                if (!bus.m0_cyc_i) begin
                    state_d    = StIdle;
                    last_gnt_d = 1'b0;
                end
            end
            StGnt1: begin
                s_cyc    = bus.m1_cyc_i;
                s_stb    = bus.m1_cyc_i & bus.m1_stb_i;
                s_we     = bus.m1_we_i;
                s_addr   = bus.m1_addr_i;
                s_wdata  = bus.m1_data_i;
                m1_stall = bus.s_stall_i;
                m1_ack   = bus.s_ack_i & bus.m1_cyc_i & (cnt_q != 4'd0);
                if (!bus.m1_cyc_i) begin
                    state_d    = StIdle;
                    last_gnt_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outstanding-strobe counter; acks arriving with nothing outstanding are dropped.
    always_comb begin
        inc   = s_stb & ~bus.s_stall_i;
        dec   = m0_ack | m1_ack;
        cnt_d = cnt_q;
        if (state_d == StIdle) begin
            cnt_d = 4'd0;
        end else if (inc && !dec && cnt_q != 4'd15) begin
            cnt_d = cnt_q + 4'd1;
        end else if (dec && !inc) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            last_gnt_q <= 1'b0;
            cnt_q      <= 4'd0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.s_cyc_o    = s_cyc;
    assign bus.s_stb_o    = s_stb;
    assign bus.s_we_o     = s_we;
    assign bus.s_addr_o   = s_addr;
    assign bus.s_data_o   = s_wdata;
    assign bus.m0_stall_o = m0_stall;
    assign bus.m1_stall_o = m1_stall;
    assign bus.m0_ack_o   = m0_ack;
    assign bus.m1_ack_o   = m1_ack;
    assign bus.m0_data_o  = bus.s_data_i;
    assign bus.m1_data_o  = bus.s_data_i;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter: grants, ties, pipelining,
// spurious acks, stores and asynchronous reset.
module tb_wb_arbiter;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    wb_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    wb_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change 1 ns after the edge, checks 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        bus.m0_cyc_i  = 1'b0; bus.m0_stb_i = 1'b0; bus.m0_addr_i = '0;
        bus.m1_cyc_i  = 1'b0; bus.m1_stb_i = 1'b0; bus.m1_we_i   = 1'b0;
        bus.m1_addr_i = '0;   bus.m1_data_i = '0;
        bus.s_stall_i = 1'b0; bus.s_ack_i  = 1'b0; bus.s_data_i  = '0;

        tick(); tick();
        rst = 1'b0;
        settle();
        check("rst_state", 32'(dut.state_q), 32'd0);
        check("rst_s_cyc", 32'(bus.s_cyc_o), 32'd0);
        check("rst_m0_stall", 32'(bus.m0_stall_o), 32'd1);
        check("rst_m1_stall", 32'(bus.m1_stall_o), 32'd1);

        // Tie after reset goes to m1
        bus.m0_cyc_i = 1'b1; bus.m1_cyc_i = 1'b1;
        settle();
        check("idle_no_cyc", 32'(bus.s_cyc_o), 32'd0);
        tick();
        check("tie1_gnt1", 32'(dut.state_q), 32'd2);
        check("tie1_m1_stall", 32'(bus.m1_stall_o), 32'd0);
        check("tie1_m0_stall", 32'(bus.m0_stall_o), 32'd1);
        bus.m1_cyc_i = 1'b0;
        settle();
        check("gnt1_exit_cyc", 32'(bus.s_cyc_o), 32'd0);
        tick();
        check("gap_idle", 32'(dut.state_q), 32'd0);
        check("gap_m0_stall", 32'(bus.m0_stall_o), 32'd1);
        tick();
        check("then_gnt0", 32'(dut.state_q), 32'd1);
        bus.m1_cyc_i = 1'b1; bus.m1_we_i = 1'b1; bus.m1_data_i = 16'h1234;
        settle();
        check("gnt0_m1_stall", 32'(bus.m1_stall_o), 32'd1);
        check("gnt0_we_zero", 32'(bus.s_we_o), 32'd0);
        check("gnt0_data_zero", 32'(bus.s_data_o), 32'd0);
        bus.m0_cyc_i = 1'b0;
        tick();
        check("gnt0_exit_idle", 32'(dut.state_q), 32'd0);
        bus.m0_cyc_i = 1'b1;
        tick();
        check("tie2_gnt1", 32'(dut.state_q), 32'd2);

        // Store from m1, then reset with two strobes outstanding
        bus.m0_cyc_i = 1'b0;
        bus.m1_stb_i = 1'b1; bus.m1_addr_i = 16'h2000;
        settle();
        check("st_we", 32'(bus.s_we_o), 32'd1);
        check("st_addr", 32'(bus.s_addr_o), 32'h2000);
        check("st_data", 32'(bus.s_data_o), 32'h1234);
        tick();
        bus.m1_addr_i = 16'h2002;
        tick();
        check("st_cnt2", 32'(dut.cnt_q), 32'd2);
        bus.m1_stb_i = 1'b0;
        rst = 1'b1;
        settle();
        check("async_rst_cyc", 32'(bus.s_cyc_o), 32'd0);
        tick();
        rst = 1'b0;
        bus.m1_cyc_i = 1'b0; bus.m1_we_i = 1'b0;
        tick();
        check("post_rst_idle", 32'(dut.state_q), 32'd0);
        check("post_rst_cnt", 32'(dut.cnt_q), 32'd0);
        check("post_rst_m0_stall", 32'(bus.m0_stall_o), 32'd1);
        check("post_rst_m1_stall", 32'(bus.m1_stall_o), 32'd1);

        // Single FETCH
        bus.m0_cyc_i = 1'b1; bus.m0_stb_i = 1'b1; bus.m0_addr_i = 16'h0100;
        settle();
        check("f_idle_stall", 32'(bus.m0_stall_o), 32'd1);
        tick();
        check("f_addr", 32'(bus.s_addr_o), 32'h0100);
        check("f_stb", 32'(bus.s_stb_o), 32'd1);
        check("f_we", 32'(bus.s_we_o), 32'd0);
        tick();
        bus.m0_stb_i = 1'b0; bus.s_ack_i = 1'b1; bus.s_data_i = 16'hFEFF;
        settle();
        check("f_ack", 32'(bus.m0_ack_o), 32'd1);
        check("f_data", 32'(bus.m0_data_o), 32'hFEFF);
        check("f_m1_ack", 32'(bus.m1_ack_o), 32'd0);
        tick();
        check("f_cnt0", 32'(dut.cnt_q), 32'd0);

        // Spurious ack with nothing outstanding
        settle();
        check("sp_ack", 32'(bus.m0_ack_o), 32'd0);
        tick();
        check("sp_cnt", 32'(dut.cnt_q), 32'd0);
        bus.s_ack_i = 1'b0; bus.m0_cyc_i = 1'b0;
        tick();
        check("sp_exit_idle", 32'(dut.state_q), 32'd0);

        // Pipelined FETCH with a stalled second strobe
        bus.m0_cyc_i = 1'b1; bus.m0_stb_i = 1'b1; bus.m0_addr_i = 16'h0010;
        tick();
        check("p_addr0", 32'(bus.s_addr_o), 32'h0010);
        check("p_m1_stall_a", 32'(bus.m1_stall_o), 32'd1);
        tick();
        bus.m0_addr_i = 16'h0011; bus.s_stall_i = 1'b1;
        settle();
        check("p_stall", 32'(bus.m0_stall_o), 32'd1);
        tick();
        check("p_cnt_hold", 32'(dut.cnt_q), 32'd1);
        check("p_addr_held", 32'(bus.s_addr_o), 32'h0011);
        bus.s_stall_i = 1'b0;
        tick();
        check("p_cnt2", 32'(dut.cnt_q), 32'd2);
        bus.m0_addr_i = 16'h0012; bus.s_ack_i = 1'b1;
        settle();
        check("p_ack1", 32'(bus.m0_ack_o), 32'd1);
        tick();
        check("p_cnt_both", 32'(dut.cnt_q), 32'd2);
        bus.m0_stb_i = 1'b0;
        tick();
        check("p_cnt1", 32'(dut.cnt_q), 32'd1);
        tick();
        bus.s_ack_i = 1'b0;
        settle();
        check("p_cnt_done", 32'(dut.cnt_q), 32'd0);
        check("p_m1_stall_b", 32'(bus.m1_stall_o), 32'd1);
        bus.m0_cyc_i = 1'b0;
        tick();
        check("p_exit_idle", 32'(dut.state_q), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
